// File: rtl/fpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_pkg
//  Description : Shared definitions for the FPU datapath family: rounding
//                mode encoding, exception flag bit positions and the
//                sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package fpu_pkg;

    typedef enum logic [1:0] {
        RNE = 2'b00,    // round to nearest, ties to even
        RTZ = 2'b01,    // round toward zero
        RUP = 2'b10,    // round toward +infinity
        RDN = 2'b11     // round toward -infinity
    } rnd_mode_e;

    // Bit positions inside the 4-bit flags vector.
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    typedef enum logic [3:0] {
        S_IDLE    = 4'd0,
        S_UNPACK  = 4'd1,
        S_SPECIAL = 4'd2,
        S_ALIGN   = 4'd3,
        S_ADD     = 4'd4,
        S_NORM    = 4'd5,
        S_ROUND   = 4'd6,
        S_PACK    = 4'd7,
        S_DONE    = 4'd8
    } fpu_state_e;

endpackage
`default_nettype wire

// File: rtl/fpu_lzc.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_lzc
//  Description : Combinational leading-zero counter. An all-zero input
//                returns WIDTH.
//  Ports       : din_i   [WIDTH-1:0]  value to scan
//                count_o [CNT_W-1:0]  number of zeros above the first 1
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_lzc
    import fpu_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] din_i,
    output logic [CNT_W-1:0] count_o
);

    // Scanning upward lets the highest set bit win without a found flag.
    always_comb begin
        count_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (din_i[i]) count_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpu_addsub_p.sv
`default_nettype none
// ============================================================================
//  Module      : fpu_addsub_p
//  Description : Parametrised multi-cycle IEEE-754 add/subtract, fixed
//                latency of 8 edges from accept to the ready pulse.
//  Ports       : clk, reset (sync, active high)
//                din1/din2 operands, op (1 = din1-din2), rnd_mode
//                valid (sampled while busy=0), busy
//                result/flags (held), ready (one-cycle pulse)
//  Revision    : 1.0 - initial release
// ============================================================================
module fpu_addsub_p
    import fpu_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [EXP_W+MAN_W:0]   din1,
    input  logic [EXP_W+MAN_W:0]   din2,
    input  logic                   op,
    input  logic [1:0]             rnd_mode,
    input  logic                   valid,
    output logic                   busy,
    output logic [EXP_W+MAN_W:0]   result,
    output logic                   ready,
    output logic [3:0]             flags
);

    localparam int W     = 1 + EXP_W + MAN_W;
    localparam int MW    = MAN_W + 4;           // hidden + fraction + G,R,S
    localparam int SW    = MAN_W + 5;           // MW plus carry
    localparam int EW    = EXP_W + 1;           // room for exponent carries
    localparam int CNT_W = $clog2(MW + 1);

    localparam logic [W-1:0] c_QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

    fpu_state_e state_q, state_d;
    logic            ready_q;
    logic [W-1:0]    result_q;
    logic [3:0]      flags_q;

    logic [W-1:0]    a_q, b_q;          // b_q already carries the op sign flip
    rnd_mode_e       rm_q;
    logic            sl_q, ss_q;        // L = larger magnitude, S = smaller
    logic [EXP_W-1:0] el_q, es_q;
    logic [MAN_W:0]  ml_q, ms_q;
    logic            spec_q, eff_sub_q;
    logic [W-1:0]    spec_res_q;
    logic [3:0]      spec_flg_q;
    logic [MW-1:0]   ms_al_q, nm_q;
    logic [SW-1:0]   sum_q;
    logic [EW-1:0]   ne_q, re_q;
    logic            zero_q, nx_q;
    logic [MAN_W:0]  rmant_q;
    logic [W-1:0]    pk_res_q;
    logic [3:0]      pk_flg_q;

    function automatic logic [EXP_W-1:0] eff_exp(input logic [EXP_W-1:0] e);
        return (e == '0) ? EXP_W'(1) : e;   // subnormals live at exponent 1
    endfunction

    // ---------------- sequencer ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (valid) state_d = S_UNPACK;
            S_UNPACK:  state_d = S_SPECIAL;
            S_SPECIAL: state_d = S_ALIGN;
            S_ALIGN:   state_d = S_ADD;
            S_ADD:     state_d = S_NORM;
            S_NORM:    state_d = S_ROUND;
            S_ROUND:   state_d = S_PACK;
            S_PACK:    state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            ready_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= (state_q == S_DONE);
            if (state_q == S_DONE) begin
                result_q <= pk_res_q;
                flags_q  <= pk_flg_q;
            end
        end
    end

    assign busy   = (state_q != S_IDLE);
    assign ready  = ready_q;
    assign result = result_q;
    assign flags  = flags_q;

    // ---------------- combinational stage logic ----------------
    logic [EXP_W-1:0] w_ea, w_eb;
    logic [MAN_W-1:0] w_fa, w_fb;
    logic             w_nan_a, w_nan_b, w_inf_a, w_inf_b;
    assign w_ea    = a_q[W-2:MAN_W];
    assign w_eb    = b_q[W-2:MAN_W];
    assign w_fa    = a_q[MAN_W-1:0];
    assign w_fb    = b_q[MAN_W-1:0];
    assign w_nan_a = (&w_ea) & (|w_fa);
    assign w_nan_b = (&w_eb) & (|w_fb);
    assign w_inf_a = (&w_ea) & ~(|w_fa);
    assign w_inf_b = (&w_eb) & ~(|w_fb);

    logic         spec_d;
    logic [W-1:0] spec_res_d;
    logic [3:0]   spec_flg_d;
    always_comb begin
        spec_d     = 1'b0;
        spec_res_d = '0;
        spec_flg_d = '0;
        if (w_nan_a | w_nan_b) begin
            spec_d              = 1'b1;
            spec_res_d          = c_QNAN;
            spec_flg_d[FLG_INV] = (w_nan_a & ~w_fa[MAN_W-1]) | (w_nan_b & ~w_fb[MAN_W-1]);
        end else if (w_inf_a & w_inf_b & (a_q[W-1] != b_q[W-1])) begin
            spec_d              = 1'b1;
            spec_res_d          = c_QNAN;
            spec_flg_d[FLG_INV] = 1'b1;
        end else if (w_inf_a) begin
            spec_d     = 1'b1;
            spec_res_d = a_q;
        end else if (w_inf_b) begin
            spec_d     = 1'b1;
            spec_res_d = b_q;
        end
    end

    // Alignment: saturating shift, every bit that falls off ORs into sticky.
    logic [MW-1:0] ms_ext, ms_al_d;
    logic [31:0]   diff32, shamt32;
    logic          sticky;
    always_comb begin
        ms_ext  = {ms_q, 3'b000};
        diff32  = 32'(el_q) - 32'(es_q);
        shamt32 = (diff32 > 32'(MAN_W + 3)) ? 32'(MAN_W + 3) : diff32;
        sticky  = 1'b0;
        for (int i = 0; i < MW; i++) begin
            if (32'(i) < shamt32) sticky = sticky | ms_ext[i];
        end
        ms_al_d = (ms_ext >> shamt32) | MW'(sticky);
    end

    logic [SW-1:0] sum_d;
    assign sum_d = eff_sub_q ? ({1'b0, ml_q, 3'b000} - {1'b0, ms_al_q})
                             : ({1'b0, ml_q, 3'b000} + {1'b0, ms_al_q});

    // Normalisation: left shift is capped so the exponent never drops below 1.
    logic [CNT_W-1:0] w_lz;
    logic [MW-1:0]    nm_d;
    logic [EW-1:0]    ne_d;
    logic [31:0]      lim32, sh32;

    fpu_lzc #(.WIDTH(MW)) u_lzc (
        .din_i   (sum_q[MW-1:0]),
        .count_o (w_lz)
    );

    always_comb begin
        lim32 = 32'(el_q) - 32'd1;
        sh32  = (32'(w_lz) < lim32) ? 32'(w_lz) : lim32;
        if (sum_q[SW-1]) begin
            nm_d = {sum_q[SW-1:2], sum_q[1] | sum_q[0]};
            ne_d = EW'(el_q) + EW'(1);
        end else begin
            nm_d = sum_q[MW-1:0] << sh32;
            ne_d = EW'(el_q) - EW'(sh32);
        end
    end

    logic             w_g, w_r, w_s, w_nx, w_up;
    logic [MAN_W+1:0] w_rnd;
    logic [MAN_W:0]   rmant_d;
    logic [EW-1:0]    re_d;
    always_comb begin
        w_g  = nm_q[2];
        w_r  = nm_q[1];
        w_s  = nm_q[0];
        w_nx = w_g | w_r | w_s;
        case (rm_q)
            RNE:     w_up = w_g & (w_r | w_s | nm_q[3]);
            RTZ:     w_up = 1'b0;
            RUP:     w_up = ~sl_q & w_nx;
            RDN:     w_up = sl_q & w_nx;
            default: w_up = 1'b0;
        endcase
        w_rnd = {1'b0, nm_q[MW-1:3]} + (MAN_W+2)'(w_up);
        if (w_rnd[MAN_W+1]) begin
            rmant_d = w_rnd[MAN_W+1:1];
            re_d    = ne_q + EW'(1);
        end else begin
            rmant_d = w_rnd[MAN_W:0];
            re_d    = ne_q;
        end
    end

    logic         w_tiny, w_ovf;
    logic [W-1:0] w_inf, w_maxf, pk_res_d;
    logic [3:0]   pk_flg_d;
    always_comb begin
        w_tiny   = ~rmant_q[MAN_W];
        w_ovf    = ~w_tiny & (re_q >= {1'b0, {EXP_W{1'b1}}});
        w_inf    = {sl_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        w_maxf   = {sl_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        pk_res_d = {sl_q, (w_tiny ? {EXP_W{1'b0}} : re_q[EXP_W-1:0]), rmant_q[MAN_W-1:0]};
        pk_flg_d = '0;
        if (spec_q) begin
            pk_res_d = spec_res_q;
            pk_flg_d = spec_flg_q;
        end else if (zero_q) begin
            // Cancellation gives +0 except under RDN; like-signed zeros keep sign.
            pk_res_d = {(eff_sub_q ? (rm_q == RDN) : sl_q), {(W-1){1'b0}}};
        end else if (w_ovf) begin
            case (rm_q)
                RNE:     pk_res_d = w_inf;
                RTZ:     pk_res_d = w_maxf;
                RUP:     pk_res_d = sl_q ? w_maxf : w_inf;
                RDN:     pk_res_d = sl_q ? w_inf : w_maxf;
                default: pk_res_d = w_inf;
            endcase
            pk_flg_d[FLG_OVF] = 1'b1;
            pk_flg_d[FLG_NX]  = 1'b1;
        end else begin
            pk_flg_d[FLG_NX]  = nx_q;
            pk_flg_d[FLG_UNF] = w_tiny & nx_q;
        end
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk) begin
        case (state_q)
            S_IDLE: if (valid) begin
                a_q  <= din1;
                b_q  <= {din2[W-1] ^ op, din2[W-2:0]};
                rm_q <= rnd_mode_e'(rnd_mode);
            end
            S_UNPACK: begin
                // Order operands by magnitude so the subtract never goes negative.
                if (a_q[W-2:0] >= b_q[W-2:0]) begin
                    sl_q <= a_q[W-1]; el_q <= eff_exp(w_ea); ml_q <= {|w_ea, w_fa};
                    ss_q <= b_q[W-1]; es_q <= eff_exp(w_eb); ms_q <= {|w_eb, w_fb};
                end else begin
                    sl_q <= b_q[W-1]; el_q <= eff_exp(w_eb); ml_q <= {|w_eb, w_fb};
                    ss_q <= a_q[W-1]; es_q <= eff_exp(w_ea); ms_q <= {|w_ea, w_fa};
                end
            end
            S_SPECIAL: begin
                spec_q     <= spec_d;
                spec_res_q <= spec_res_d;
                spec_flg_q <= spec_flg_d;
                eff_sub_q  <= sl_q ^ ss_q;
            end
            S_ALIGN: ms_al_q <= ms_al_d;
            S_ADD:   sum_q   <= sum_d;
            S_NORM: begin
                nm_q   <= nm_d;
                ne_q   <= ne_d;
                zero_q <= (sum_q == '0);
            end
            S_ROUND: begin
                rmant_q <= rmant_d;
                re_q    <= re_d;
                nx_q    <= w_nx;
            end
            S_PACK: begin
                pk_res_q <= pk_res_d;
                pk_flg_q <= pk_flg_d;
            end
            default: ;
        endcase
    end

endmodule
`default_nettype wire
